sprite_vga_top: RTL and testbench
=================================

Name:
sprite_vga_top

Overview:
- Top-level of the sprite demo: generates 640x480@60 Hz VGA timing from a single 25 MHz clock.
- Runs a two-state game FSM (IDLE/PLAY) and moves a 32x32 square sprite under key control.
- Outputs registered RGB/sync signals to the DE2-115 VGA DAC.
- Sits directly under the board pin wrapper.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (frame total 525)
- SPRITE_SIZE, 32, sprite edge length in pixels
- STEP, 4, pixels moved per frame per held key

Ports:
- i_clk  in  1  25 MHz system/pixel clock
- i_rst_n  in  1  asynchronous, active-high reset (1 = reset); name kept per codebase convention
- i_key2  in  1  move negative (left/up), active-high level
- i_key3  in  1  move positive (right/down), active-high level
- i_sw0  in  1  axis select: 0 = horizontal, 1 = vertical
- i_start  in  1  start request, active-high level
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_CLK  out  1  pixel clock = i_clk, passed through
- VGA_BLANK_N  out  1  1 during the active region
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_SYNC_N  out  1  constant 0
- state  out  1  0 = IDLE, 1 = PLAY

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Input synchronisation: i_key2, i_key3, i_sw0 and i_start each pass a 2-flop synchroniser; all logic uses the synchronised versions.
- Counters:
  - h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps and counts 0..524, then wraps to 0.
- Sync and blank (combinational):
  - hs_c = 0 while h_cnt is 656..751.
  - vs_c = 0 while v_cnt is 490..491.
  - active = (h_cnt < 640) and (v_cnt < 480).
- Output register: RGB, HS, VS and BLANK_N are registered, so outputs lag the counters by exactly 1 cycle.
- Frame tick: asserted for one cycle when h_cnt = 799 and v_cnt = 524.
- FSM:
  - IDLE -> PLAY when synchronised start = 1; takes effect on any cycle, not only at the frame tick.
  - PLAY is terminal until reset.
  - Port state = (FSM == PLAY).
- Sprite position (x, y):
  - Reset value (304, 224), i.e. centred.
  - Updates only on the frame tick while in PLAY.
  - Axis: i_sw0 = 0 -> x axis, i_sw0 = 1 -> y axis.
  - key3 only: coordinate += STEP. key2 only: coordinate -= STEP. Both or neither: no change.
  - Clamp x to 0..608 and y to 0..448 (saturate, no wrap).
- Pixel colour when active:
  - IDLE: dark blue 0x000040.
  - PLAY: red 0xFF0000 inside the sprite (x <= h < x+32 and y <= v < y+32); otherwise black.
- Blanking: outside the active region RGB = 0 and BLANK_N = 0.
- Reset values: h_cnt = v_cnt = 0; FSM = IDLE; outputs HS = 1, VS = 1, BLANK_N = 0, RGB = 0, state = 0.
- Reset mid-frame: timing restarts at (0,0) and the sprite re-centres.

Optional Feature:
- Macro SCREEN_BORDER_EN.
- When defined: in PLAY, active pixels with h = 0, h = 639, v = 0 or v = 479 are white 0xFFFFFF. The sprite has priority over the border.
- When undefined: no border is drawn; behaviour is exactly as specified above.

Decomposition:
- Package sprite_vga_pkg holds:
  - the timing constants;
  - colour constants (COL_BG_IDLE, COL_SPRITE, COL_BLACK, COL_BORDER);
  - the game state enum typedef {IDLE, PLAY}.
- One sub-module, vga_timing, contains the h/v counters and produces hs_c, vs_c, active, h_cnt, v_cnt and the frame tick.
- The top holds the synchronisers, FSM, sprite registers, pixel mux and output registers.

Test Plan:
- Reset, then release:
  - outputs HS = 1, VS = 1, BLANK_N = 0, RGB = 0, state = 0.
  - first active pixel RGB = 0x000040, appearing 1 cycle after the counters reach (0,0).
- Line/frame timing: HS low for exactly 96 cycles per 800-cycle line; VS low for exactly 1600 cycles per 420000-cycle frame; BLANK_N high for 640 cycles per visible line.
- Start: assert i_start for 1 cycle -> state = 1 within 3 cycles; pixel (320,240) is red and pixel (100,100) is black.
- Movement: in PLAY with sw0 = 0, hold key3 for 3 frame ticks -> x = 316; then hold key2 and key3 together for 1 tick -> x stays 316.
- Clamp and axis: hold key3 for 200 ticks -> x = 608; set sw0 = 1 and hold key2 for 100 ticks -> y = 0.
- Reset in PLAY: -> state = 0, sprite back at (304,224), counters restart from 0.

Source files
------------

// File: rtl/sprite_vga_pkg.sv
// Shared constants and types for the sprite VGA demo: default 640x480@60 timing,
// palette and game state encoding.
package sprite_vga_pkg;
    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SPRITE_SIZE = 32;
    localparam int DEF_STEP        = 4;

    localparam logic [23:0] COL_BG_IDLE = 24'h000040;
    localparam logic [23:0] COL_SPRITE  = 24'hFF0000;
    localparam logic [23:0] COL_BLACK   = 24'h000000;
    localparam logic [23:0] COL_BORDER  = 24'hFFFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } game_state_e;
endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters with combinational sync, active-region
// and end-of-frame tick decode.
module vga_timing
    import sprite_vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_active,
    output logic             o_frame_tick
);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign o_h_cnt      = h_cnt_q;
    assign o_v_cnt      = v_cnt_q;
    assign o_hs         = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    assign o_vs         = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    assign o_active     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign o_frame_tick = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
endmodule

// File: rtl/sprite_vga_top.sv
// Sprite demo top: input synchronisers, IDLE/PLAY game FSM, key-driven sprite and
// registered VGA outputs. Define SCREEN_BORDER_EN to draw a white frame border in PLAY.
module sprite_vga_top
    import sprite_vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
    parameter int STEP        = DEF_STEP
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key2,
    input  logic       i_key3,
    input  logic       i_sw0,
    input  logic       i_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_BLANK_N,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_SYNC_N,
    output logic       state
);
    localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [CNT_W-1:0] X_RST  = CNT_W'((H_ACTIVE - SPRITE_SIZE) / 2);
    localparam logic [CNT_W-1:0] Y_RST  = CNT_W'((V_ACTIVE - SPRITE_SIZE) / 2);
    localparam logic [CNT_W:0]   SIZE_W = (CNT_W + 1)'(SPRITE_SIZE);
`ifdef SCREEN_BORDER_EN
    localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(V_ACTIVE - 1);
`endif

    // Saturating move of one coordinate; opposing keys cancel.
    function automatic logic [CNT_W-1:0] step_coord(input logic [CNT_W-1:0] c,
                                                    input logic [CNT_W-1:0] lim,
                                                    input logic inc, input logic dec);
        logic [CNT_W:0] sum;
        sum        = {1'b0, c} + {1'b0, STEP_V};
        step_coord = c;
        if (inc && !dec)
            step_coord = (sum > {1'b0, lim}) ? lim : sum[CNT_W-1:0];
        else if (dec && !inc)
            step_coord = (c < STEP_V) ? '0 : c - STEP_V;
    endfunction

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             hs_c, vs_c, active, frame_tick;
    logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic             key2_s, key3_s, sw0_s, start_s;
    game_state_e      state_q, state_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             in_sprite;
    logic [23:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk       (i_clk),
        .i_rst       (i_rst_n),
        .o_h_cnt     (h_cnt),
        .o_v_cnt     (v_cnt),
        .o_hs        (hs_c),
        .o_vs        (vs_c),
        .o_active    (active),
        .o_frame_tick(frame_tick)
    );

    assign {start_s, sw0_s, key3_s, key2_s} = sync2_q;

    always_comb begin
        sync1_d = {i_start, i_sw0, i_key3, i_key2};
        sync2_d = sync1_q;
        state_d = state_q;
        if (state_q == IDLE && start_s)
            state_d = PLAY;
        x_d = x_q;
        y_d = y_q;
        if (state_q == PLAY && frame_tick) begin
            if (sw0_s) y_d = step_coord(y_q, Y_MAX, key3_s, key2_s);
            else       x_d = step_coord(x_q, X_MAX, key3_s, key2_s);
        end
    end

    assign in_sprite = (h_cnt >= x_q) && ({1'b0, h_cnt} < {1'b0, x_q} + SIZE_W) &&
                       (v_cnt >= y_q) && ({1'b0, v_cnt} < {1'b0, y_q} + SIZE_W);

    always_comb begin
        rgb_d = COL_BLACK;
        if (active) begin
            if (state_q == IDLE)
                rgb_d = COL_BG_IDLE;
            else if (in_sprite)
                rgb_d = COL_SPRITE;
`ifdef SCREEN_BORDER_EN
            else if (h_cnt == '0 || h_cnt == H_EDGE || v_cnt == '0 || v_cnt == V_EDGE)
                rgb_d = COL_BORDER;
`endif
        end
        hs_d      = hs_c;
        vs_d      = vs_c;
        blank_n_d = active;
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= IDLE;
            x_q       <= X_RST;
            y_q       <= Y_RST;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_CLK     = i_clk;
    assign VGA_SYNC_N  = 1'b0;
    assign state       = (state_q == PLAY);
endmodule

// File: tb/tb_sprite_vga_top.sv
// Directed bench for sprite_vga_top on a reduced screen geometry; sprite positions
// are queued when key stimulus is applied and checked against a scanned frame.
module tb_sprite_vga_top;
    localparam int HA = 40, HFP = 2, HSW = 4, HBP = 2;
    localparam int VA = 24, VFP = 2, VSW = 2, VBP = 2;
    localparam int S = 8, STP = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int F  = HT * VT;
    localparam int X0 = (HA - S) / 2, Y0 = (VA - S) / 2;
    localparam int XMAX = HA - S, YMAX = VA - S;

    logic clk = 1'b0;
    logic rst, key2, key3, sw0, start;
    logic [7:0] r, g, b;
    logic vclk, blank_n, hs, vs, sync_n, st;
    logic [23:0] rgb;
    int errors = 0, checks = 0, cyc = 0;

    typedef struct { int x; int y; } pos_t;
    pos_t sb[$];

    always #20 clk = ~clk;
    assign rgb = {r, g, b};

    sprite_vga_top #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SPRITE_SIZE(S), .STEP(STP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst), .i_key2(key2), .i_key3(key3), .i_sw0(sw0),
        .i_start(start), .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_CLK(vclk),
        .VGA_BLANK_N(blank_n), .VGA_HS(hs), .VGA_VS(vs), .VGA_SYNC_N(sync_n),
        .state(st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance until the output register shows pixel (h, v).
    task automatic wait_pix(input int h, input int v);
        int n = 0;
        while (((cyc - 1) % F) != v * HT + h && n < 2 * F) begin
            step();
            n++;
        end
        checks++;
        assert (n < 2 * F) else begin
            errors++;
            $error("FAIL wait_pix(%0d,%0d): waited=%0d limit=%0d", h, v, n, 2 * F);
        end
    endtask

    // Hold keys across exactly n frame ticks and queue the resulting position.
    task automatic move(input logic k3, input logic k2, input logic s, input int n,
                        input int ex, input int ey);
        wait_pix(10, 0);
        key3 = k3; key2 = k2; sw0 = s;
        repeat (n * F) step();
        key3 = 1'b0; key2 = 1'b0;
        sb.push_back('{ex, ey});
    endtask

    task automatic measure_sprite(input string tag);
        int minh = 9999, minv = 9999, maxh = -1, cnt = 0, p;
        pos_t e;
        wait_pix(HT - 1, VT - 1);
        for (int i = 0; i < F; i++) begin
            step();
            p = (cyc - 1) % F;
            if (rgb == 24'hFF0000) begin
                cnt++;
                if (p % HT < minh) minh = p % HT;
                if (p % HT > maxh) maxh = p % HT;
                if (p / HT < minv) minv = p / HT;
            end
        end
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty", tag);
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        chk($sformatf("%s x", tag), minh, e.x);
        chk($sformatf("%s y", tag), minv, e.y);
        chk($sformatf("%s right", tag), maxh, e.x + S - 1);
        chk($sformatf("%s area", tag), cnt, S * S);
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2 && !st; i++) step();
        chk("start state", st, 1);
    endtask

    initial begin
        int hs_lo, vs_lo, bl_hi, idle_px, line_hs, dirty;
        rst = 1'b1; key2 = 1'b0; key3 = 1'b0; sw0 = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst hs", hs, 1);
        chk("rst vs", vs, 1);
        chk("rst blank_n", blank_n, 0);
        chk("rst rgb", rgb, 0);
        chk("rst state", st, 0);
        chk("sync_n", sync_n, 0);
        chk("vga_clk", vclk, clk);
        rst = 1'b0;
        cyc = 0;
        chk("lag rgb", rgb, 0);
        step();
        chk("first px rgb", rgb, 24'h000040);
        chk("first px blank_n", blank_n, 1);

        wait_pix(HA - 1, 1);
        chk("last active blank_n", blank_n, 1);
        step();
        chk("first blank blank_n", blank_n, 0);
        chk("first blank rgb", rgb, 0);
        wait_pix(HA + HFP - 1, 1);
        chk("hs before", hs, 1);
        step();
        chk("hs start", hs, 0);
        wait_pix(HA + HFP + HSW - 1, 1);
        chk("hs last", hs, 0);
        step();
        chk("hs end", hs, 1);
        wait_pix(HT - 1, VA + VFP - 1);
        chk("vs before", vs, 1);
        step();
        chk("vs start", vs, 0);
        wait_pix(HT - 1, VA + VFP + VSW - 1);
        chk("vs last", vs, 0);
        step();
        chk("vs end", vs, 1);

        wait_pix(HT - 1, VT - 1);
        hs_lo = 0; vs_lo = 0; bl_hi = 0; idle_px = 0; line_hs = 0; dirty = 0;
        for (int i = 0; i < F; i++) begin
            step();
            if (!hs) hs_lo++;
            if (!hs && i < HT) line_hs++;
            if (!vs) vs_lo++;
            if (blank_n) bl_hi++;
            if (rgb == 24'h000040) idle_px++;
            if (!blank_n && rgb != 0) dirty++;
        end
        chk("line hs low", line_hs, HSW);
        chk("frame hs low", hs_lo, HSW * VT);
        chk("frame vs low", vs_lo, VSW * HT);
        chk("frame blank_n high", bl_hi, HA * VA);
        chk("idle pixels", idle_px, HA * VA);
        chk("blank rgb", dirty, 0);

        wait_pix(20, 3);
        press_start();
        sb.push_back('{X0, Y0});
        wait_pix(HA / 2, VA / 2);
        chk("centre red", rgb, 24'hFF0000);
        wait_pix(5, 5);
        chk("off-sprite black", rgb, 0);
        wait_pix(0, 0);
`ifdef SCREEN_BORDER_EN
        chk("corner", rgb, 24'hFFFFFF);
`else
        chk("corner", rgb, 0);
`endif
        measure_sprite("start");
        chk("play terminal", st, 1);

        move(1'b1, 1'b0, 1'b0, 3, X0 + 3 * STP, Y0);
        measure_sprite("right3");
        move(1'b1, 1'b1, 1'b0, 1, X0 + 3 * STP, Y0);
        measure_sprite("both keys");
        move(1'b1, 1'b0, 1'b0, 6, XMAX, Y0);
        measure_sprite("clamp right");
        move(1'b0, 1'b1, 1'b1, 6, XMAX, 0);
        measure_sprite("clamp up");

        wait_pix(20, 5);
        rst = 1'b1;
        #1;
        chk("midrst state", st, 0);
        chk("midrst hs", hs, 1);
        chk("midrst vs", vs, 1);
        chk("midrst blank_n", blank_n, 0);
        chk("midrst rgb", rgb, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sw0 = 1'b0;
        cyc = 0;
        step();
        chk("restart px rgb", rgb, 24'h000040);
        chk("restart blank_n", blank_n, 1);
        wait_pix(20, 3);
        press_start();
        sb.push_back('{X0, Y0});
        measure_sprite("recentre");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
